// File: rtl/multicycle_ctrl_if.sv
// Memory request/ready handshake between the multicycle control FSM and the
// memory system; the controller is the master.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_wren;
  logic mem_addr_sel;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_wren,
    output mem_addr_sel,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_wren,
    input  mem_addr_sel,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// RV32I multicycle control FSM: fetch/decode/exec/mem/writeback sequencing with a
// retired-instruction counter. Define ILLEGAL_TRAP_EN to trap unknown opcodes instead of halting.
module multicycle_ctrl #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_ctrl_if.master    mem,
  input  logic [6:0]           opcode,
  input  logic                 branch_taken,
  output logic                 pc_en,
  output logic [1:0]           pc_sel,
  output logic                 ir_en,
  output logic                 regfile_wren,
  output logic                 alu_src_a_sel,
  output logic                 alu_src_b_sel,
  output logic [1:0]           wb_sel,
  output logic                 halted,
  output logic                 trap,
  output logic [CNT_WIDTH-1:0] instret
);

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OP_IMM = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111,
    OPC_SYSTEM = 7'b1110011
  } rv32i_opcode_t;

`ifdef ILLEGAL_TRAP_EN
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
`else
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ILLEGAL} state_t;
`endif

  state_t state_q, state_d;
  logic   retire;
  logic   known;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      instret <= '0;
    end else begin
      state_q <= state_d;
      if (retire) instret <= instret + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    known = 1'b0;
    case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP,
      OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM: known = 1'b1;
      default: known = 1'b0;
    endcase
  end

  // Outputs are forced low while rst is held so that mem_req only rises after release.
  always_comb begin
    state_d          = state_q;
    retire           = 1'b0;
    mem.mem_req      = 1'b0;
    mem.mem_wren     = 1'b0;
    mem.mem_addr_sel = 1'b0;
    pc_en            = 1'b0;
    pc_sel           = 2'd0;
    ir_en            = 1'b0;
    regfile_wren     = 1'b0;
    alu_src_a_sel    = 1'b0;
    alu_src_b_sel    = 1'b0;
    wb_sel           = 2'd0;
    halted           = 1'b0;
    trap             = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem.mem_req = 1'b1;
          if (mem.mem_ready) begin
            ir_en   = 1'b1;
            state_d = S_DECODE;
          end
        end
        S_DECODE: begin
`ifdef ILLEGAL_TRAP_EN
          state_d = known ? S_EXEC : S_TRAP;
`else
          state_d = known ? S_EXEC : S_ILLEGAL;
`endif
        end
        S_EXEC: begin
          state_d = S_WB;
          case (opcode)
            OPC_OP_IMM, OPC_JALR: alu_src_b_sel = 1'b1;
            OPC_LOAD, OPC_STORE: begin
              alu_src_b_sel = 1'b1;
              state_d       = S_MEM;
            end
            OPC_AUIPC, OPC_JAL: begin
              alu_src_a_sel = 1'b1;
              alu_src_b_sel = 1'b1;
            end
            OPC_BRANCH: begin
              pc_en   = 1'b1;
              pc_sel  = {1'b0, branch_taken};
              retire  = 1'b1;
              state_d = S_FETCH;
            end
            OPC_SYSTEM: begin
              pc_en   = 1'b1;
              retire  = 1'b1;
              state_d = S_FETCH;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          mem.mem_req      = 1'b1;
          mem.mem_addr_sel = 1'b1;
          mem.mem_wren     = (opcode == OPC_STORE);
          if (mem.mem_ready) begin
            if (opcode == OPC_STORE) begin
              pc_en   = 1'b1;
              retire  = 1'b1;
              state_d = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end
        end
        S_WB: begin
          regfile_wren = 1'b1;
          pc_en        = 1'b1;
          retire       = 1'b1;
          state_d      = S_FETCH;
          case (opcode)
            OPC_LOAD: wb_sel = 2'd1;
            OPC_JAL, OPC_JALR: begin
              wb_sel = 2'd2;
              pc_sel = 2'd1;
            end
            OPC_LUI: wb_sel = 2'd3;
            default: wb_sel = 2'd0;
          endcase
        end
`ifdef ILLEGAL_TRAP_EN
        S_TRAP: begin
          trap    = 1'b1;
          pc_sel  = 2'd2;
          pc_en   = 1'b1;
          state_d = S_FETCH;
        end
`else
        S_ILLEGAL: halted = 1'b1;
`endif
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected control vectors are queued
// with their stimulus and compared on the falling edge.
module tb_multicycle_ctrl;
  localparam int unsigned CW = 4;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic          clk;
  logic          rst;
  logic [6:0]    opcode;
  logic          branch_taken;
  logic          pc_en;
  logic [1:0]    pc_sel;
  logic          ir_en;
  logic          regfile_wren;
  logic          alu_src_a_sel;
  logic          alu_src_b_sel;
  logic [1:0]    wb_sel;
  logic          halted;
  logic          trap;
  logic [CW-1:0] instret;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.CNT_WIDTH(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem           (bus),
    .opcode        (opcode),
    .branch_taken  (branch_taken),
    .pc_en         (pc_en),
    .pc_sel        (pc_sel),
    .ir_en         (ir_en),
    .regfile_wren  (regfile_wren),
    .alu_src_a_sel (alu_src_a_sel),
    .alu_src_b_sel (alu_src_b_sel),
    .wb_sel        (wb_sel),
    .halted        (halted),
    .trap          (trap),
    .instret       (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {req, wren, addr_sel, pc_en, pc_sel, ir_en, rf_wren, a_sel, b_sel, wb_sel, halted, trap}
  logic [13:0] obs;
  assign obs = {bus.mem_req, bus.mem_wren, bus.mem_addr_sel, pc_en, pc_sel, ir_en,
                regfile_wren, alu_src_a_sel, alu_src_b_sel, wb_sel, halted, trap};

  typedef struct packed {
    logic        ready;
    logic        taken;
    logic [13:0] vec;
  } step_t;

  step_t         sb[$];
  int unsigned   vectors = 0;
  int unsigned   miscompares = 0;
  logic [CW-1:0] exp_instret = '0;

  function automatic logic [13:0] mk(input logic req, input logic wren, input logic asel,
                                     input logic pce, input logic [1:0] pcs, input logic ire,
                                     input logic rfw, input logic a, input logic b,
                                     input logic [1:0] wb, input logic hlt, input logic trp);
    return {req, wren, asel, pce, pcs, ire, rfw, a, b, wb, hlt, trp};
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(1));
  endfunction

  // Expected cycle-by-cycle behaviour of one instruction, with fetch/memory wait states.
  task automatic push_instr(input logic [6:0] opc, input logic taken,
                            input int unsigned fwait, input int unsigned mwait);
    logic a, b, pce, st;
    logic [1:0] pcs, wb;
    a = 1'b0; b = 1'b0; pce = 1'b0; pcs = 2'd0; wb = 2'd0;
    st = (opc == OP_STORE);
    for (int unsigned i = 0; i < fwait; i++)
      sb.push_back('{1'b0, taken, mk(1,0,0,0,2'd0,0,0,0,0,2'd0,0,0)});
    sb.push_back('{1'b1, taken, mk(1,0,0,0,2'd0,1,0,0,0,2'd0,0,0)});
    sb.push_back('{rnd(), taken, 14'd0});
    case (opc)
      OP_OPIMM, OP_LOAD, OP_STORE, OP_JALR: b = 1'b1;
      OP_AUIPC, OP_JAL: begin a = 1'b1; b = 1'b1; end
      OP_BRANCH: begin pce = 1'b1; pcs = {1'b0, taken}; end
      OP_SYSTEM: pce = 1'b1;
      default: ;
    endcase
    sb.push_back('{rnd(), taken, mk(0,0,0,pce,pcs,0,0,a,b,2'd0,0,0)});
    if (opc == OP_BRANCH || opc == OP_SYSTEM) begin
      exp_instret++;
      return;
    end
    if (opc == OP_LOAD || opc == OP_STORE) begin
      for (int unsigned i = 0; i < mwait; i++)
        sb.push_back('{1'b0, taken, mk(1,st,1,0,2'd0,0,0,0,0,2'd0,0,0)});
      sb.push_back('{1'b1, taken, mk(1,st,1,st,2'd0,0,0,0,0,2'd0,0,0)});
      if (st) begin
        exp_instret++;
        return;
      end
    end
    pcs = (opc == OP_JAL || opc == OP_JALR) ? 2'd1 : 2'd0;
    case (opc)
      OP_LOAD: wb = 2'd1;
      OP_JAL, OP_JALR: wb = 2'd2;
      OP_LUI: wb = 2'd3;
      default: wb = 2'd0;
    endcase
    sb.push_back('{rnd(), taken, mk(0,0,0,1,pcs,0,1,0,0,wb,0,0)});
    exp_instret++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    opcode = OP_OP;
    branch_taken = 1'b0;
    bus.mem_ready = 1'b1;
    #1 rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (obs !== 14'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b required %b", obs, 14'd0);
    end
    vectors++;
    if (instret !== '0) begin
      miscompares++;
      $display("FAIL reset_instret: got %0d required 0", instret);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_instret = '0;
  endtask

  task automatic test_alu_ops();
    logic [6:0] ops [6];
    ops = '{OP_OP, OP_OPIMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};
    for (int unsigned k = 0; k < 6; k++) begin
      opcode = ops[k];
      push_instr(ops[k], 1'b0, (k == 0) ? 0 : k % 3, 0);
      while (sb.size() != 0) begin
        step_t s;
        s = sb.pop_front();
        bus.mem_ready = s.ready;
        branch_taken = s.taken;
        @(negedge clk);
        vectors++;
        if (obs !== s.vec) begin
          miscompares++;
          $display("FAIL alu_op_%b: got %b required %b", ops[k], obs, s.vec);
        end
        @(posedge clk); #1;
      end
      vectors++;
      if (instret !== exp_instret) begin
        miscompares++;
        $display("FAIL alu_instret_%b: got %0d required %0d", ops[k], instret, exp_instret);
      end
    end
  endtask

  task automatic test_load();
    opcode = OP_LOAD;
    push_instr(OP_LOAD, 1'b0, 0, 3);
    while (sb.size() != 0) begin
      step_t s;
      s = sb.pop_front();
      bus.mem_ready = s.ready;
      branch_taken = s.taken;
      @(negedge clk);
      vectors++;
      if (obs !== s.vec) begin
        miscompares++;
        $display("FAIL load_cycle: got %b required %b", obs, s.vec);
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (instret !== exp_instret) begin
      miscompares++;
      $display("FAIL load_instret: got %0d required %0d", instret, exp_instret);
    end
  endtask

  task automatic test_store();
    for (int unsigned w = 0; w < 2; w++) begin
      opcode = OP_STORE;
      push_instr(OP_STORE, 1'b0, w, w * 2);
      while (sb.size() != 0) begin
        step_t s;
        s = sb.pop_front();
        bus.mem_ready = s.ready;
        branch_taken = s.taken;
        @(negedge clk);
        vectors++;
        if (obs !== s.vec) begin
          miscompares++;
          $display("FAIL store_cycle: got %b required %b", obs, s.vec);
        end
        @(posedge clk); #1;
      end
      vectors++;
      if (instret !== exp_instret) begin
        miscompares++;
        $display("FAIL store_instret: got %0d required %0d", instret, exp_instret);
      end
    end
  endtask

  task automatic test_branch();
    for (int unsigned t = 0; t < 2; t++) begin
      opcode = OP_BRANCH;
      push_instr(OP_BRANCH, (t == 0), 0, 0);
      while (sb.size() != 0) begin
        step_t s;
        s = sb.pop_front();
        bus.mem_ready = s.ready;
        branch_taken = s.taken;
        @(negedge clk);
        vectors++;
        if (obs !== s.vec) begin
          miscompares++;
          $display("FAIL branch_taken%0d: got %b required %b", (t == 0), obs, s.vec);
        end
        @(posedge clk); #1;
      end
      vectors++;
      if (instret !== exp_instret) begin
        miscompares++;
        $display("FAIL branch_instret: got %0d required %0d", instret, exp_instret);
      end
    end
  endtask

  task automatic test_system();
    opcode = OP_SYSTEM;
    push_instr(OP_SYSTEM, 1'b1, 1, 0);
    while (sb.size() != 0) begin
      step_t s;
      s = sb.pop_front();
      bus.mem_ready = s.ready;
      branch_taken = s.taken;
      @(negedge clk);
      vectors++;
      if (obs !== s.vec) begin
        miscompares++;
        $display("FAIL system_cycle: got %b required %b", obs, s.vec);
      end
      @(posedge clk); #1;
    end
  endtask

  // Enough mixed instructions to wrap the narrow counter.
  task automatic test_back_to_back();
    logic [6:0] ops [5];
    ops = '{OP_OP, OP_LOAD, OP_BRANCH, OP_STORE, OP_JAL};
    for (int unsigned k = 0; k < 18; k++) begin
      opcode = ops[k % 5];
      push_instr(ops[k % 5], rnd(), $urandom_range(1), $urandom_range(2));
      while (sb.size() != 0) begin
        step_t s;
        s = sb.pop_front();
        bus.mem_ready = s.ready;
        branch_taken = s.taken;
        @(negedge clk);
        vectors++;
        if (obs !== s.vec) begin
          miscompares++;
          $display("FAIL b2b_%0d: got %b required %b", k, obs, s.vec);
        end
        @(posedge clk); #1;
      end
    end
    vectors++;
    if (instret !== exp_instret) begin
      miscompares++;
      $display("FAIL b2b_instret_wrap: got %0d required %0d", instret, exp_instret);
    end
  endtask

  task automatic test_mid_reset();
    opcode = OP_STORE;
    sb.push_back('{1'b1, 1'b0, mk(1,0,0,0,2'd0,1,0,0,0,2'd0,0,0)});
    sb.push_back('{1'b0, 1'b0, 14'd0});
    sb.push_back('{1'b0, 1'b0, mk(0,0,0,0,2'd0,0,0,0,1,2'd0,0,0)});
    sb.push_back('{1'b0, 1'b0, mk(1,1,1,0,2'd0,0,0,0,0,2'd0,0,0)});
    while (sb.size() != 0) begin
      step_t s;
      s = sb.pop_front();
      bus.mem_ready = s.ready;
      branch_taken = s.taken;
      @(negedge clk);
      vectors++;
      if (obs !== s.vec) begin
        miscompares++;
        $display("FAIL midrst_pre: got %b required %b", obs, s.vec);
      end
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (obs !== 14'd0) begin
      miscompares++;
      $display("FAIL midrst_outputs: got %b required %b", obs, 14'd0);
    end
    vectors++;
    if (instret !== '0) begin
      miscompares++;
      $display("FAIL midrst_instret: got %0d required 0", instret);
    end
    exp_instret = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    opcode = OP_OP;
    push_instr(OP_OP, 1'b0, 0, 0);
    while (sb.size() != 0) begin
      step_t s;
      s = sb.pop_front();
      bus.mem_ready = s.ready;
      branch_taken = s.taken;
      @(negedge clk);
      vectors++;
      if (obs !== s.vec) begin
        miscompares++;
        $display("FAIL midrst_restart: got %b required %b", obs, s.vec);
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (instret !== exp_instret) begin
      miscompares++;
      $display("FAIL midrst_instret_after: got %0d required %0d", instret, exp_instret);
    end
  endtask

  task automatic test_illegal();
    opcode = 7'b0000000;
    sb.push_back('{1'b1, 1'b0, mk(1,0,0,0,2'd0,1,0,0,0,2'd0,0,0)});
    sb.push_back('{1'b1, 1'b0, 14'd0});
`ifdef ILLEGAL_TRAP_EN
    sb.push_back('{1'b1, 1'b0, mk(0,0,0,1,2'd2,0,0,0,0,2'd0,0,1)});
    sb.push_back('{1'b0, 1'b0, mk(1,0,0,0,2'd0,0,0,0,0,2'd0,0,0)});
`else
    for (int unsigned i = 0; i < 10; i++)
      sb.push_back('{rnd(), rnd(), mk(0,0,0,0,2'd0,0,0,0,0,2'd0,1,0)});
`endif
    while (sb.size() != 0) begin
      step_t s;
      s = sb.pop_front();
      bus.mem_ready = s.ready;
      branch_taken = s.taken;
      @(negedge clk);
      vectors++;
      if (obs !== s.vec) begin
        miscompares++;
        $display("FAIL illegal_cycle: got %b required %b", obs, s.vec);
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (instret !== exp_instret) begin
      miscompares++;
      $display("FAIL illegal_instret: got %0d required %0d", instret, exp_instret);
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_load();
    test_store();
    test_branch();
    test_system();
    test_back_to_back();
    test_mid_reset();
    test_illegal();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multicycle control FSM that sequences the RV32I datapath: fetch, decode, execute, memory access and writeback.
- Consumes the decoded opcode and branch compare result from the datapath.
- Drives the enables and mux selects: PC, instruction register, register file, memory.
- Handshakes with memory through a req/ready pair so variable-latency memory is supported.
- Keeps a retired-instruction counter.

Parameters:
CNT_WIDTH, 32, width of the retired-instruction counter instret.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
opcode  input  7  rv32i_opcode_t from instruction register (instruction[6:0])
branch_taken  input  1  datapath branch-compare result, valid in EXEC
mem_ready  input  1  memory completed current request this cycle
mem_req  output  1  memory request strobe
mem_wren  output  1  memory write (valid with mem_req)
mem_addr_sel  output  1  0 = PC, 1 = ALU result
pc_en  output  1  PC register load enable
pc_sel  output  2  0 = PC+4, 1 = ALU result, 2 = trap vector
ir_en  output  1  instruction register load enable
regfile_wren  output  1  register file write enable
alu_src_a_sel  output  1  0 = rs1, 1 = PC
alu_src_b_sel  output  1  0 = rs2, 1 = immediate
wb_sel  output  2  0 = ALU, 1 = memory data, 2 = PC+4, 3 = immediate (LUI)
halted  output  1  core stopped on illegal opcode
trap  output  1  one-cycle illegal-instruction pulse (feature only; else tied 0)
instret  output  CNT_WIDTH  instructions retired since reset

Behaviour:
Reset:
- rst high, asynchronous: state=FETCH; instret=0; halted=0.
- Every output is combinational from state and is 0 in reset. mem_req rises the first cycle after rst deasserts.
- Reset mid-transaction abandons the memory access; nothing is written.

States and transitions:
- FETCH: mem_req=1, mem_addr_sel=0, mem_wren=0.
  - Stay while mem_ready=0.
  - On mem_ready=1: ir_en=1, go DECODE.
- DECODE: one cycle, no enables.
  - Known opcode -> EXEC.
  - Unknown opcode -> ILLEGAL.
- EXEC: one cycle. ALU select by opcode:
  - OP: a=rs1, b=rs2.
  - OP_IMM, LOAD, STORE, JALR: a=rs1, b=imm.
  - AUIPC, JAL: a=PC, b=imm.
  - BRANCH: a=rs1, b=rs2 for the compare. Taken -> pc_sel=1 and pc_en=1, using the target computed by the datapath. Not taken -> pc_sel=0 and pc_en=1. Then FETCH; instret increments.
  - LOAD/STORE -> MEM.
  - SYSTEM: treated as NOP; pc_sel=0, pc_en=1, instret++, then FETCH.
  - All other opcodes -> WB.
- MEM: mem_req=1, mem_addr_sel=1, mem_wren=(opcode==STORE).
  - Hold while mem_ready=0.
  - On mem_ready, LOAD -> WB.
  - On mem_ready, STORE: pc_sel=0, pc_en=1, instret++, then FETCH.
- WB: one cycle. regfile_wren=1.
  - wb_sel: LOAD=1, JAL/JALR=2, LUI=3, otherwise 0.
  - pc_en=1. pc_sel=1 for JAL/JALR, else 0.
  - instret++, then FETCH.
- ILLEGAL: halted=1. Stay here until rst; no enables asserted.

Invariants:
- pc_en, ir_en and regfile_wren are never asserted in the same cycle as each other, except pc_en with regfile_wren in WB.
- mem_wren=1 only in MEM with STORE.
- instret wraps modulo 2^CNT_WIDTH.

Latency with zero-wait memory (mem_ready same cycle as req):
- ALU ops: 4 cycles.
- Loads: 5 cycles.
- Stores and branches: 4 and 3 cycles.

Optional Feature:
ILLEGAL_TRAP_EN:
- Defined: DECODE with an unknown opcode goes to TRAP instead of ILLEGAL. TRAP is one cycle: trap=1, pc_sel=2, pc_en=1, instret unchanged; then FETCH. halted stays 0.
- Undefined: trap is tied 0, and the sticky ILLEGAL state above applies.

Test Plan:
- Reset release, mem_ready=1, opcode=OP (0110011) -> FETCH/DECODE/EXEC/WB in 4 cycles; regfile_wren=1 only in cycle 4 with wb_sel=0; instret=1.
- LOAD (0000011) with mem_ready low 3 cycles in MEM -> mem_req held with mem_addr_sel=1 for 4 cycles; WB with wb_sel=1; no early regfile_wren.
- STORE (0100011) -> mem_wren=1 only in MEM; regfile_wren never asserted; instret increments once.
- BRANCH (1100011): branch_taken=1 -> pc_sel=1 in EXEC; branch_taken=0 -> pc_sel=0. Both take 3 cycles with no register write.
- Opcode 0000000 -> halted=1 after DECODE and stays set for 10 cycles; no further mem_req. With ILLEGAL_TRAP_EN: trap pulse, pc_sel=2, then mem_req in FETCH.
- Assert rst during MEM wait with mem_wren=1 -> all outputs 0 immediately, instret=0; after release FETCH restarts.
